hub75_scan_driver: RTL and testbench



---
 rtl/hub75_scan_driver_pkg.sv | 12 +
 rtl/hub75_scan_driver_if.sv | 12 +
 rtl/hub75_bcm_timer.sv | 24 ++
 rtl/hub75_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_hub75_scan_driver.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/hub75_scan_driver_pkg.sv
// Shared types and constants for the HUB75 scan-out path.
package hub75_pkg;
  typedef enum logic [2:0] {
    IDLE, RD_TOP, RD_BOT, DATA, CLK, BLANK, LATCH, SHOW
  } state_t;

  localparam int R_LSB        = 8;
  localparam int G_LSB        = 4;
  localparam int B_LSB        = 0;
  localparam int PANEL_HEIGHT = 32;
  localparam int ROW_PAIRS    = PANEL_HEIGHT / 2;
endpackage

// File: rtl/hub75_scan_driver_if.sv
// Frame-buffer synchronous read port: data returns the cycle after rd_en.
interface hub75_fb_if #(
  parameter int ADDR_W = 14,
  parameter int BPP    = 12
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [BPP-1:0]    rd_data;

  modport master (output rd_en, rd_addr, input  rd_data);
  modport slave  (input  rd_en, rd_addr, output rd_data);
endinterface

// File: rtl/hub75_bcm_timer.sv
// BCM on-time down-counter: loads BASE_TIME<<plane, done marks the last on cycle.
module hub75_bcm_timer #(
  parameter int BASE_TIME = 8,
  parameter int BPC       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [$clog2(BPC)-1:0] plane,
  output logic                   done
);
  localparam int CNT_W = $clog2(BASE_TIME << (BPC - 1)) + 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (load)        cnt <= CNT_W'(BASE_TIME) << plane;
    else if (cnt != '0)   cnt <= cnt - CNT_W'(1);
  end

  // Loaded with N on entry, so count==1 is the Nth on cycle.
  assign done = (cnt == CNT_W'(1));
endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 panel scanner: fetches top/bottom pixels, shifts them out per BCM plane,
// latches the row and shows it for a plane-weighted time.
module hub75_scan_driver import hub75_pkg::*; #(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 2 * ROW_PAIRS,
  parameter int BPP       = 12,
  parameter int BPC       = 4,
  parameter int ADDR_W    = 14,
  parameter int BASE_TIME = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  hub75_fb_if.master fb,
  output logic       frame_start,
  output logic       sclk,
  output logic       lat,
  output logic       oe,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       r0,
  output logic       g0,
  output logic       b0,
  output logic       r1,
  output logic       g1,
  output logic       b1
);
  localparam int RP    = HEIGHT / 2;
  localparam int ROW_W = $clog2(RP);
  localparam int COL_W = $clog2(WIDTH);
  localparam int PL_W  = $clog2(BPC);
  localparam int IDX_W = $clog2(BPP);

  state_t           state, state_nx;
  logic [ROW_W-1:0] row, row_nx, abcd_q;
  logic [COL_W-1:0] col, col_nx;
  logic [PL_W-1:0]  plane, plane_nx;
  logic [BPP-1:0]   top_q;
  logic [5:0]       rgb_q, rgb_cur;
  logic [IDX_W-1:0] ri, gi, bi;
  logic             tmr_load, tmr_done, fs_nx;

  hub75_bcm_timer #(.BASE_TIME(BASE_TIME), .BPC(BPC)) u_bcm (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .plane (plane),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      plane <= '0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      col   <= col_nx;
      plane <= plane_nx;
    end
  end

  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    plane_nx = plane;
    tmr_load = 1'b0;
    fs_nx    = 1'b0;
    case (state)
      IDLE: if (enable) begin
        state_nx = RD_TOP;
        row_nx   = '0;
        col_nx   = '0;
        plane_nx = '0;
        fs_nx    = 1'b1;
      end
      RD_TOP: state_nx = RD_BOT;
      RD_BOT: state_nx = DATA;
      DATA:   state_nx = CLK;
      CLK: begin
        if (col == COL_W'(WIDTH - 1)) begin
          col_nx   = '0;
          state_nx = BLANK;
        end else begin
          col_nx   = col + COL_W'(1);
          state_nx = RD_TOP;
        end
      end
      BLANK: state_nx = LATCH;
      LATCH: begin
        tmr_load = 1'b1;
        state_nx = SHOW;
      end
      SHOW: if (tmr_done) begin
        if (plane == PL_W'(BPC - 1)) begin
          plane_nx = '0;
          if (row == ROW_W'(RP - 1)) begin
            row_nx = '0;
            fs_nx  = enable;
          end else begin
            row_nx = row + ROW_W'(1);
          end
        end else begin
          plane_nx = plane + PL_W'(1);
        end
        // enable is only honoured at a plane boundary so the panel never sees a torn plane
        state_nx = enable ? RD_TOP : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    fb.rd_en   = 1'b0;
    fb.rd_addr = '0;
    case (state)
      RD_TOP: begin
        fb.rd_en   = 1'b1;
        fb.rd_addr = ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col);
      end
      RD_BOT: begin
        fb.rd_en   = 1'b1;
        fb.rd_addr = (ADDR_W'(row) + ADDR_W'(RP)) * ADDR_W'(WIDTH) + ADDR_W'(col);
      end
      default: ;
    endcase
  end

  always_comb begin
    ri      = IDX_W'(R_LSB) + IDX_W'(plane);
    gi      = IDX_W'(G_LSB) + IDX_W'(plane);
    bi      = IDX_W'(B_LSB) + IDX_W'(plane);
    rgb_cur = {top_q[ri], top_q[gi], top_q[bi],
               fb.rd_data[ri], fb.rd_data[gi], fb.rd_data[bi]};
  end

  // Bottom pixel arrives during DATA; show it live there, then hold it through CLK.
  assign {r0, g0, b0, r1, g1, b1} = (state == DATA) ? rgb_cur : rgb_q;
  assign {d, c, b, a} = abcd_q;

  // Panel pins are registered from the next state so they toggle cleanly on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q       <= '0;
      rgb_q       <= '0;
      sclk        <= 1'b0;
      lat         <= 1'b0;
      oe          <= 1'b1;
      abcd_q      <= '0;
      frame_start <= 1'b0;
    end else begin
      if (state == RD_BOT)   top_q  <= fb.rd_data;
      if (state == DATA)     rgb_q  <= rgb_cur;
      if (state_nx == LATCH) abcd_q <= row;
      sclk        <= (state_nx == CLK);
      lat         <= (state_nx == LATCH);
      oe          <= (state_nx != SHOW);
      frame_start <= fs_nx;
    end
  end
endmodule

// File: tb/tb_hub75_scan_driver.sv
// Scoreboard bench for hub75_scan_driver: stimulus queues expectations, a negedge monitor checks them.
module tb_hub75_scan_driver;
  import hub75_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic mem_const = 1'b0;
  always #5 clk = ~clk;

  hub75_fb_if #(.ADDR_W(14), .BPP(12)) fb ();
  logic frame_start, sclk, lat, oe, a, b, c, d, r0, g0, b0, r1, g1, b1;

  hub75_scan_driver #(
    .WIDTH(64), .HEIGHT(32), .BPP(12), .BPC(4), .ADDR_W(14), .BASE_TIME(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fb(fb),
    .frame_start(frame_start), .sclk(sclk), .lat(lat), .oe(oe),
    .a(a), .b(b), .c(c), .d(d),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1)
  );

  // Memory model: pixel value is the low 12 address bits, or a constant colour.
  always @(posedge clk) begin
    if (!rst_n)         fb.rd_data <= '0;
    else if (fb.rd_en)  fb.rd_data <= mem_const ? 12'hA5C : fb.rd_addr[11:0];
  end

  typedef struct { int row; int gap; } lat_exp_t;
  int       exp_addr[$];
  logic [5:0] exp_rgb[$];
  int       exp_show[$];
  lat_exp_t exp_lat[$];

  int n_vec = 0, n_bad = 0;
  int lat_cnt = 0, fs_cnt = 0, rd_cnt = 0;
  int run = 0, gap = 0;
  logic lat_prev = 1'b0, lat_at_show = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] px_bits(input logic [11:0] px, input int p);
    logic [11:0] s;
    s = px >> p;
    return {s[8], s[4], s[0]};
  endfunction

  // Monitor: consumes expectations whenever the DUT presents a read, shift, latch or show.
  always @(negedge clk) begin
    int e;
    lat_exp_t le;
    if (!rst_n) begin
      run = 0; gap = 0; lat_prev = 1'b0;
    end else begin
      if (fb.rd_en) begin
        rd_cnt++;
        if (exp_addr.size() > 0) begin
          e = exp_addr.pop_front();
          check("rd_addr", 32'(fb.rd_addr), e);
        end
      end
      if (sclk && exp_rgb.size() > 0)
        check("rgb", 32'({r0, g0, b0, r1, g1, b1}), 32'(exp_rgb.pop_front()));
      if (frame_start) begin fs_cnt++; gap = 1; end
      else if (oe && !lat) gap++;
      if (!oe) begin
        if (run == 0) lat_at_show = lat_prev;
        run++;
        gap = 0;
      end else if (run > 0) begin
        if (exp_show.size() > 0) begin
          e = exp_show.pop_front();
          check("show_len", run, e);
          check("lat_before_show", 32'(lat_at_show), 32'd1);
        end
        run = 0;
      end
      if (lat) begin
        lat_cnt++;
        if (exp_lat.size() > 0) begin
          le = exp_lat.pop_front();
          check("latch_row", 32'({d, c, b, a}), le.row);
          check("shift_cycles", gap, le.gap);
        end
      end
      lat_prev = lat;
    end
  end

  logic [2:0] cexp [4];
  int base, snap;

  initial begin
    // plane p of 0xA5C as {r,g,b}
    cexp[0] = 3'b010; cexp[1] = 3'b100; cexp[2] = 3'b011; cexp[3] = 3'b101;

    rst_n = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({oe, sclk, lat, d, c, b, a, fb.rd_en, frame_start,
                             r0, g0, b0, r1, g1, b1, fb.rd_addr}), 32'h1000_0000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_quiet", 32'({oe, rd_cnt == 0, fs_cnt == 0}), 32'd7);

    // Full frame with address-valued pixels, plus row 0 again and row 1 plane 0.
    for (int i = 0; i < 4; i++) begin exp_addr.push_back(i); exp_addr.push_back(1024 + i); end
    for (int col = 0; col < 64; col++)
      exp_rgb.push_back({px_bits(12'(col), 0), px_bits(12'(1024 + col), 0)});
    for (int r = 0; r < 17; r++)
      for (int p = 0; p < 4; p++) begin
        exp_lat.push_back('{r % 16, 257});
        exp_show.push_back(8 << p);
      end
    exp_lat.push_back('{1, 257});
    enable = 1'b1;

    for (int i = 0; i < 25000 && lat_cnt < 65; i++) @(negedge clk);
    check("frame_wrap_fs", fs_cnt, 2);
    for (int i = 0; i < 3000 && lat_cnt < 69; i++) @(negedge clk);
    for (int i = 0; i < 50 && oe; i++) @(negedge clk);
    check("reach_row1_show", 32'({lat_cnt >= 69, oe, d, c, b, a}), 32'b100001);
    repeat (3) @(negedge clk);
    rst_n = 1'b0; enable = 1'b0;
    #1;
    check("reset_mid_show", 32'({oe, sclk, lat, d, c, b, a, fb.rd_en}), 32'b1000_0000);
    check("frame_drain", exp_lat.size() + exp_show.size() + exp_addr.size() + exp_rgb.size(), 0);
    snap = rd_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_idle", 32'({oe, rd_cnt == snap, d, c, b, a}), 32'b110000);

    // Constant colour 0xA5C, drop enable during plane 2 shift.
    mem_const = 1'b1;
    base = lat_cnt;
    for (int i = 0; i < 2; i++) begin exp_addr.push_back(i); exp_addr.push_back(1024 + i); end
    for (int p = 0; p < 3; p++) begin
      for (int col = 0; col < 64; col++) exp_rgb.push_back({cexp[p], cexp[p]});
      exp_lat.push_back('{0, 257});
      exp_show.push_back(8 << p);
    end
    enable = 1'b1;
    for (int i = 0; i < 2000 && lat_cnt < base + 2; i++) @(negedge clk);
    for (int i = 0; i < 50 && oe; i++) @(negedge clk);
    for (int i = 0; i < 100 && !oe; i++) @(negedge clk);
    check("plane2_shift_start", 32'({lat_cnt - base == 2, oe}), 32'b11);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 1000 && lat_cnt < base + 3; i++) @(negedge clk);
    for (int i = 0; i < 50 && oe; i++) @(negedge clk);
    for (int i = 0; i < 100 && !oe; i++) @(negedge clk);
    snap = rd_cnt;
    repeat (300) @(negedge clk);
    check("drop_no_reads", rd_cnt - snap, 0);
    check("drop_idle_oe", 32'(oe), 32'd1);
    check("drop_planes", lat_cnt - base, 3);
    check("drop_drain", exp_lat.size() + exp_show.size() + exp_addr.size() + exp_rgb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
